// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
// Register map (word addresses BASE_ADDR + offset):
//   0 DATA     write pushes din[7:0] into the FIFO; reads 0
//   1 STATUS   read {count[7:4], overflow, busy, full, empty}; write din[3]=1 clears overflow
//   2 DIVISOR  clocks per serial bit; 0 behaves as 1
//   3 (none)   reads 0, writes ignored
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   addr   bus address
//   din    bus write data
//   we     bus write enable
//   dout   registered read data (0 when not selected)
//   sel    registered: dout owns the system read mux this cycle
//   tx     serial output, idle high, driven from a flop
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  output logic [15:0] dout,
  output logic        sel,
  output logic        tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        period_q, period_d;
  logic [15:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               sel_q, sel_d;
  logic [15:0]        dout_q, dout_d;

  logic        hit, wr_hit, push_req, push, pop;
  logic        fifo_empty, fifo_full, bit_done;
  logic [1:0]  off;
  logic [15:0] cnt_ext, status;

  always_comb begin
    hit        = (addr[15:2] == BASE_ADDR[15:2]);
    off        = addr[1:0];
    wr_hit     = we & hit;
    push_req   = wr_hit && (off == 2'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    bit_done   = (clk_cnt_q == period_q - 16'd1);
    // Pop when idle, or at the last clock of STOP so frames run back to back.
    pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    push       = push_req && (!fifo_full || pop);
    cnt_ext    = 16'(count_q);
    status     = {8'h00, cnt_ext[3:0], ovf_q, (state_q != IDLE), fifo_full, fifo_empty};

    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    div_d     = div_q;
    period_d  = period_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;

    case (state_q)
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          clk_cnt_d = 16'd0;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d = 16'd0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase

    // Starting a frame overrides the STOP->IDLE transition above.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q];
      period_d  = (div_q == 16'd0) ? 16'd1 : div_q;
      clk_cnt_d = 16'd0;
      bit_cnt_d = 3'd0;
      state_d   = START;
      tx_d      = 1'b0;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = din[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Clear first so a same-cycle overflow set wins.
    if (wr_hit && (off == 2'd1) && din[3]) ovf_d = 1'b0;
    if (push_req && !push)                 ovf_d = 1'b1;
    if (wr_hit && (off == 2'd2))           div_d = din;

    sel_d  = hit & ~we;
    dout_d = 16'd0;
    if (sel_d) begin
      case (off)
        2'd1:    dout_d = status;
        2'd2:    dout_d = div_q;
        default: dout_d = 16'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= 16'(CLKS_PER_BIT);
      period_q  <= 16'd1;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
      sel_q     <= 1'b0;
      dout_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      period_q  <= period_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
    end
  end

  // Byte storage and shift register carry data only; no reset needed.
  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    shift_q <= shift_d;
  end

  assign dout = dout_q;
  assign sel  = sel_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, we, sel, tx;
  logic [15:0] addr, din, dout;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we),
    .dout(dout), .sel(sel), .tx(tx)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of bytes, and the current frame as a 10-bit
  // pattern indexed by (clocks since frame start / bit period).
  logic [7:0]  mq [$];
  bit          m_ovf, m_busy, m_live, m_hit, m_pop;
  logic [15:0] m_div, m_dout;
  int          m_tick, m_period, m_size;
  logic [9:0]  m_bits;
  logic        m_tx, m_sel;
  logic [7:0]  m_b;

  initial begin
    m_live = 0; m_tx = 1'b1; m_sel = 1'b0; m_dout = 16'd0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_ovf = 0; m_busy = 0; m_tick = 0; m_div = 16'(CPB);
        m_tx = 1'b1; m_sel = 1'b0; m_dout = 16'd0; m_live = 1;
      end else begin
        m_hit  = (addr[15:2] == BASE[15:2]);
        m_size = mq.size();
        m_sel  = m_hit && !we;
        m_dout = 16'd0;
        if (m_sel) begin
          if (addr[1:0] == 2'd1)
            m_dout = {8'h00, 4'(m_size), m_ovf, m_busy, (m_size == DEPTH), (m_size == 0)};
          else if (addr[1:0] == 2'd2)
            m_dout = m_div;
        end
        if (m_busy) begin
          m_tick++;
          if (m_tick == 10 * m_period) m_busy = 0;
        end
        m_pop = !m_busy && (m_size > 0);
        if (m_pop) begin
          m_b      = mq.pop_front();
          m_busy   = 1;
          m_tick   = 0;
          m_period = (m_div == 16'd0) ? 1 : int'(m_div);
          m_bits   = {1'b1, m_b, 1'b0};
        end
        if (we && m_hit && addr[1:0] == 2'd1 && din[3]) m_ovf = 0;
        if (we && m_hit && addr[1:0] == 2'd0) begin
          if (m_size < DEPTH || m_pop) mq.push_back(din[7:0]);
          else m_ovf = 1;
        end
        if (we && m_hit && addr[1:0] == 2'd2) m_div = din;
        m_tx = m_busy ? m_bits[m_tick / m_period] : 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("tx",   {15'd0, tx},  {15'd0, m_tx});
        check("sel",  {15'd0, sel}, {15'd0, m_sel});
        check("dout", dout, m_dout);
      end
    end
  end

  // Both tasks start and end at a falling edge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000; din = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp_d, input logic exp_s, input string name);
    addr = a; we = 1'b0;
    @(posedge clk); #1;
    check({name, "_dout"}, dout, exp_d);
    check({name, "_sel"}, {15'd0, sel}, {15'd0, exp_s});
    @(negedge clk);
    addr = 16'h0000;
  endtask

  logic [9:0] a5_bits;
  int r;

  initial begin
    reset = 1'b1; we = 1'b0; addr = 16'h0000; din = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_tx", {15'd0, tx}, 16'd1);
    rd(16'hFF01, 16'h0001, 1'b1, "status_reset");
    rd(16'hFF02, 16'h0010, 1'b1, "div_reset");

    // Single frame 0xA5 at 16 clocks per bit, sampled mid-bit
    a5_bits = 10'b11_0100_1010;
    wr(16'hFF00, 16'h00A5);
    @(posedge clk); #1;
    check("a5_fall", {15'd0, tx}, 16'd0);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 8 : 16) @(posedge clk);
      #1;
      check("a5_bit", {15'd0, tx}, {15'd0, a5_bits[b]});
    end
    repeat (10) @(negedge clk);
    rd(16'hFF01, 16'h0001, 1'b1, "a5_idle");

    // Six consecutive writes with depth 4: the sixth overflows
    for (int i = 1; i <= 6; i++) wr(16'hFF00, 16'(i));
    rd(16'hFF01, 16'h004E, 1'b1, "ovf_status");
    wr(16'hFF01, 16'h0008);
    rd(16'hFF01, 16'h0046, 1'b1, "ovf_cleared");
    repeat (5 * 160 + 20) @(negedge clk);
    rd(16'hFF01, 16'h0001, 1'b1, "drain_idle");

    // Back-to-back frames: busy exactly 20 bit periods
    wr(16'hFF00, 16'h003C);
    wr(16'hFF00, 16'h00C3);
    repeat (319) @(negedge clk);
    rd(16'hFF01, 16'h0005, 1'b1, "b2b_last_clk");
    rd(16'hFF01, 16'h0001, 1'b1, "b2b_done");

    // Divisor 0 acts as 1; a mid-frame divisor change applies to the next frame
    wr(16'hFF02, 16'h0000);
    wr(16'hFF00, 16'h00FF);
    @(posedge clk); #1;
    check("div0_start", {15'd0, tx}, 16'd0);
    @(posedge clk); #1;
    check("div0_d0", {15'd0, tx}, 16'd1);
    @(negedge clk);
    wr(16'hFF02, 16'h0004);
    wr(16'hFF00, 16'h003C);
    rd(16'hFF02, 16'h0004, 1'b1, "div4_read");
    repeat (60) @(negedge clk);

    // Reset in the middle of the data bits
    wr(16'hFF02, 16'h0010);
    wr(16'hFF00, 16'h0000);
    wr(16'hFF00, 16'h00AA);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_tx", {15'd0, tx}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    rd(16'hFF01, 16'h0001, 1'b1, "reset_mid_status");
    repeat (50) @(negedge clk);
    rd(16'hFF01, 16'h0001, 1'b1, "reset_no_frames");

    // Unmapped offset and out-of-range address
    rd(16'hFF03, 16'h0000, 1'b1, "off3");
    rd(16'hFEFF, 16'h0000, 1'b0, "miss");
    wr(16'hFF03, 16'hFFFF);
    rd(16'hFF02, 16'h0010, 1'b1, "off3_write_ignored");

    // Random traffic with small divisors
    wr(16'hFF02, 16'h0002);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      @(negedge clk);
      else if (r < 60) wr(16'hFF00, 16'($urandom));
      else if (r < 70) wr(16'hFF01, 16'($urandom));
      else if (r < 75) wr(16'hFF02, 16'($urandom_range(0, 3)));
      else if (r < 90) begin
        addr = BASE + 16'($urandom_range(0, 3)); we = 1'b0;
        @(negedge clk);
        addr = 16'h0000;
      end else begin
        addr = 16'($urandom_range(0, 16'hFEFF)); we = 1'b0;
        @(negedge clk);
        addr = 16'h0000;
      end
    end
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
